// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave in front of a word-addressed, byte-strobed on-chip RAM.
// One transaction in flight at a time; writes win over reads when both are
// offered. The RAM is built as four byte-wide lanes so each lane maps onto a
// plain single-write-port block RAM with a registered read.
module axi_lite_ram_slave #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    // read address / data
    input  logic [31:0] ARdata,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [2:0]  ARprot,
    output logic [31:0] Rdata,
    output logic [1:0]  Rresp,
    output logic        Rvalid,
    input  logic        RReady,
    // write address / data / response
    input  logic [31:0] AWdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [2:0]  AWprot,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wvalid,
    output logic        Wready,
    output logic [1:0]  Bresp,
    output logic        Bvalid,
    input  logic        Bready
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + MEM_BYTES;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_EXEC = 3'd1;
    localparam logic [2:0] RD_RESP = 3'd2;
    localparam logic [2:0] WR_EXEC = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]       state_reg, state_next;
    logic             aw_cap_reg, w_cap_reg;
    logic [IDX_W-1:0] wr_idx_reg, rd_idx_reg;
    logic             wr_err_reg, rd_err_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       wstrb_reg;
    logic [1:0]       rresp_reg, bresp_reg;
    logic [31:0]      ram_word;

    logic        is_idle, ar_hs, aw_hs, w_hs;
    logic        aw_in_range, ar_in_range;
    logic [31:0] aw_off, ar_off;

    // Offsets are computed modulo 2^32; the range test is done 33 bits wide
    // so a window ending exactly at 4 GiB still decodes correctly.
    assign aw_off      = AWdata - BASE_ADDR;
    assign ar_off      = ARdata - BASE_ADDR;
    assign aw_in_range = ({1'b0, AWdata} >= BASE_EXT) && ({1'b0, AWdata} < LIMIT_EXT);
    assign ar_in_range = ({1'b0, ARdata} >= BASE_EXT) && ({1'b0, ARdata} < LIMIT_EXT);

    // Ready terms: a pending write address on the bus or a half-captured write
    // holds off reads, so writes always go first. All readies drop in reset.
    assign is_idle = (state_reg == IDLE) && !rst;
    assign ARready = is_idle && !AWvalid && !aw_cap_reg && !w_cap_reg;
    assign AWready = is_idle && !aw_cap_reg;
    assign Wready  = is_idle && !w_cap_reg;

    assign ar_hs = ARvalid && ARready;
    assign aw_hs = AWvalid && AWready;
    assign w_hs  = Wvalid && Wready;

    // Responses come straight from registers.
    assign Rvalid = (state_reg == RD_RESP);
    assign Bvalid = (state_reg == WR_RESP);
    assign Rresp  = rresp_reg;
    assign Bresp  = bresp_reg;
    assign Rdata  = rresp_reg[1] ? ERR_DATA : ram_word;

    // Next-state decode; a read and a completing write cannot coincide
    // because ARready excludes any write activity.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if ((aw_cap_reg || aw_hs) && (w_cap_reg || w_hs)) begin
                    state_next = WR_EXEC;
                end else if (ar_hs) begin
                    state_next = RD_EXEC;
                end
            end
            RD_EXEC: state_next = RD_RESP;
            RD_RESP: if (RReady) state_next = IDLE;
            WR_EXEC: state_next = WR_RESP;
            WR_RESP: if (Bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, capture flags and response codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            aw_cap_reg <= 1'b0;
            w_cap_reg  <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            bresp_reg  <= RESP_OKAY;
        end else begin
            state_reg <= state_next;
            if (aw_hs) aw_cap_reg <= 1'b1;
            if (w_hs)  w_cap_reg  <= 1'b1;
            if (state_reg == WR_EXEC) begin
                aw_cap_reg <= 1'b0;
                w_cap_reg  <= 1'b0;
                bresp_reg  <= wr_err_reg ? RESP_SLVERR : RESP_OKAY;
            end
            if (state_reg == RD_EXEC) begin
                rresp_reg <= rd_err_reg ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Captured address/data payload; only meaningful while its flag is set.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            wr_idx_reg <= aw_off[IDX_W+1:2];
            wr_err_reg <= !aw_in_range;
        end
        if (w_hs) begin
            wdata_reg <= Wdata;
            wstrb_reg <= Wstrb;
        end
        if (ar_hs) begin
            rd_idx_reg <= ar_off[IDX_W+1:2];
            rd_err_reg <= !ar_in_range;
        end
    end

    // One block RAM per byte lane with its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [MEM_WORDS];
        logic [7:0] rd_byte_reg;

        // Byte-lane write port and registered read port.
        always_ff @(posedge clk) begin
            if (!rst && state_reg == WR_EXEC && !wr_err_reg && wstrb_reg[gi]) begin
                mem[wr_idx_reg] <= wdata_reg[8*gi +: 8];
            end
            if (rst) begin
                rd_byte_reg <= 8'h00;
            end else if (state_reg == RD_EXEC) begin
                rd_byte_reg <= mem[rd_idx_reg];
            end
        end

        assign ram_word[8*gi +: 8] = rd_byte_reg;
    end

    // Protection bits and sub-word / out-of-window offset bits are not used.
    logic unused_bits;
    assign unused_bits = ^{ARprot, AWprot, aw_off[1:0], ar_off[1:0],
                           aw_off[31:IDX_W+2], ar_off[31:IDX_W+2]};

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave: write/read, strobes, split write,
// backpressure, write priority, out-of-range and reset behaviour.
module tb_axi_lite_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ARdata, AWdata, Wdata, Rdata;
    logic        ARvalid, ARready, Rvalid, RReady;
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic [2:0]  ARprot, AWprot;
    logic [3:0]  Wstrb;
    logic [1:0]  Rresp, Bresp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_ram_slave #(
        .MEM_WORDS(1024),
        .BASE_ADDR(32'h0000_0000),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
        .Rdata(Rdata), .Rresp(Rresp), .Rvalid(Rvalid), .RReady(RReady),
        .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
        .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
        .Bresp(Bresp), .Bvalid(Bvalid), .Bready(Bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        AWdata = a; Wdata = d; Wstrb = s; AWvalid = 1'b1; Wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            #1;
            hs_aw = AWvalid && AWready;
            hs_w  = Wvalid && Wready;
            @(posedge clk);
            if (hs_aw) aw_done = 1'b1;
            if (hs_w)  w_done  = 1'b1;
            @(negedge clk);
            if (aw_done) AWvalid = 1'b0;
            if (w_done)  Wvalid  = 1'b0;
            n++;
        end
        AWvalid = 1'b0; Wvalid = 1'b0;
        check($sformatf("wr_accept %h", a), 32'(aw_done && w_done), 32'd1);
        lat = 1;
        while (!Bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        resp = Bresp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        bit done, hs;
        int n;
        ARdata = a; ARvalid = 1'b1; done = 1'b0; n = 0;
        while (!done && n < 20) begin
            #1;
            hs = ARvalid && ARready;
            @(posedge clk);
            if (hs) done = 1'b1;
            @(negedge clk);
            n++;
        end
        ARvalid = 1'b0;
        check($sformatf("rd_accept %h", a), 32'(done), 32'd1);
        lat = 1;
        while (!Rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = Rdata; resp = Rresp;
        if (RReady) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          n;

        rst = 1'b1;
        ARdata = '0; AWdata = '0; Wdata = '0; Wstrb = '0;
        ARvalid = 1'b0; AWvalid = 1'b0; Wvalid = 1'b0;
        ARprot = 3'b000; AWprot = 3'b000;
        RReady = 1'b1; Bready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_readys", {29'd0, ARready, AWready, Wready}, 32'd0);
        check("rst_valids", {30'd0, Rvalid, Bvalid}, 32'd0);
        check("rst_rdata", Rdata, 32'd0);
        check("rst_resps", {28'd0, Rresp, Bresp}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_readys", {29'd0, ARready, AWready, Wready}, 32'd7);
        @(negedge clk);

        // Full-word write then read back
        axi_write(32'h10, 32'hCAFE_BABE, 4'hF, r, lat);
        check("wr10_bresp", 32'(r), 32'd0);
        check("wr10_lat", 32'(lat), 32'd2);
        axi_read(32'h10, d, r, lat);
        check("rd10_data", d, 32'hCAFE_BABE);
        check("rd10_rresp", 32'(r), 32'd0);
        check("rd10_lat", 32'(lat), 32'd2);

        // Byte strobes
        axi_write(32'h20, 32'h1122_3344, 4'hF, r, lat);
        axi_write(32'h20, 32'hAABB_CCDD, 4'b0101, r, lat);
        check("strb_bresp", 32'(r), 32'd0);
        axi_read(32'h20, d, r, lat);
        check("strb_data", d, 32'h11BB_33DD);

        // Split write: W at cycle 0, AW at cycle 3
        Wdata = 32'h0F0F_1234; Wstrb = 4'hF; Wvalid = 1'b1;
        #1;
        check("split_c0_readys", {30'd0, AWready, Wready}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        Wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("split_c%0d_aw_w_ar", c), {29'd0, AWready, Wready, ARready}, 32'b100);
            if (c < 3) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        AWdata = 32'h40; AWvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        AWvalid = 1'b0;
        lat = 1;
        while (!Bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("split_lat", 32'(lat), 32'd2);
        check("split_bresp", 32'(Bresp), 32'd0);
        @(posedge clk);
        @(negedge clk);
        axi_read(32'h40, d, r, lat);
        check("split_data", d, 32'h0F0F_1234);

        // Read backpressure: RReady low for 5 cycles
        RReady = 1'b0;
        ARdata = 32'h10; ARvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ARvalid = 1'b0;
        n = 0;
        while (!Rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            ARdata = 32'h20; ARvalid = 1'b1;
            #1;
            check($sformatf("bp%0d_rvalid_arready", c), {30'd0, Rvalid, ARready}, 32'b10);
            check($sformatf("bp%0d_rdata", c), Rdata, 32'hCAFE_BABE);
            @(posedge clk);
            @(negedge clk);
        end
        ARvalid = 1'b0; RReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_rvalid", 32'(Rvalid), 32'd0);

        // Priority: AR and AW together, write must complete first
        ARdata = 32'h50; ARvalid = 1'b1;
        AWdata = 32'h50; AWvalid = 1'b1; Wdata = 32'h7766_5544; Wstrb = 4'hF; Wvalid = 1'b1;
        #1;
        check("prio_ar_aw_ready", {30'd0, ARready, AWready}, 32'b01);
        axi_write(32'h50, 32'h7766_5544, 4'hF, r, lat);
        check("prio_bresp", 32'(r), 32'd0);
        axi_read(32'h50, d, r, lat);
        check("prio_rd_after_wr", d, 32'h7766_5544);

        // Out of range
        axi_write(32'h0, 32'h0BAD_F00D, 4'hF, r, lat);
        axi_read(32'h1000, d, r, lat);
        check("oor_rdata", d, 32'hDEAD_BEEF);
        check("oor_rresp", 32'(r), 32'd2);
        axi_write(32'h1000, 32'h1234_5678, 4'hF, r, lat);
        check("oor_bresp", 32'(r), 32'd2);
        axi_read(32'h0, d, r, lat);
        check("oor_word0_kept", d, 32'h0BAD_F00D);

        // Empty strobe
        axi_write(32'h10, 32'hFFFF_FFFF, 4'h0, r, lat);
        check("strb0_bresp", 32'(r), 32'd0);
        axi_read(32'h10, d, r, lat);
        check("strb0_data", d, 32'hCAFE_BABE);

        // Reset after AW, before W
        axi_write(32'h30, 32'h5555_AAAA, 4'hF, r, lat);
        AWdata = 32'h30; AWvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        AWvalid = 1'b0;
        rst = 1'b1; Wdata = 32'h0000_0000; Wstrb = 4'hF; Wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstw_rdy_vld", {27'd0, ARready, AWready, Wready, Rvalid, Bvalid}, 32'd0);
        rst = 1'b0; Wvalid = 1'b0;
        @(negedge clk);
        axi_read(32'h30, d, r, lat);
        check("rstw_word_kept", d, 32'h5555_AAAA);

        // Reset while Rvalid is high
        RReady = 1'b0;
        ARdata = 32'h20; ARvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ARvalid = 1'b0;
        n = 0;
        while (!Rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstr_rvalid_before", 32'(Rvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstr_rvalid_after", 32'(Rvalid), 32'd0);
        check("rstr_rdata_after", Rdata, 32'd0);
        rst = 1'b0; RReady = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
- AXI4-Lite slave holding a word-addressed, byte-strobed on-chip RAM.
- Sits directly downstream of the core's AXI4-Lite master port and serves both instruction fetches and load/store traffic.
- Port names mirror the core's bus names so the two wire together by name. ARdata and AWdata carry addresses.
- One outstanding transaction at a time, matching the master's behaviour.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to MEM_WORDS*4.
- ERR_DATA, 32'hDEAD_BEEF: Rdata value returned for an out-of-range read.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ARdata  in  32  read byte address.
- ARvalid  in  1  read address valid.
- ARready  out  1  read address accepted.
- Rdata  out  32  read data.
- Rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- Rvalid  out  1  read data valid.
- RReady  in  1  master accepts read data.
- AWdata  in  32  write byte address.
- AWvalid  in  1  write address valid.
- AWready  out  1  write address accepted.
- Wdata  in  32  write data.
- Wstrb  in  4  byte enables; bit i enables Wdata[8i+7:8i].
- Wvalid  in  1  write data valid.
- Wready  out  1  write data accepted.
- Bresp  out  2  write response, same encoding as Rresp.
- Bvalid  out  1  write response valid.
- Bready  in  1  master accepts write response.
- ARprot, AWprot  in  3 each  accepted and ignored.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All ready/valid outputs are 0.
  - Rdata=0, Rresp=0, Bresp=0.
  - Both capture flags clear.
  - RAM contents are not cleared.
  - Reset mid-transaction abandons the transaction; a write whose AW and W were not both captured never modifies RAM.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - An address is in range when BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*4.
- State machine:
  - IDLE: ARready = ~AWvalid & ~aw_cap & ~w_cap. AWready = ~aw_cap. Wready = ~w_cap.
  - IDLE, write channels: AW and W may complete in the same cycle or in either order. Each completed handshake latches its address or data+strobe and sets aw_cap or w_cap.
  - IDLE -> WR_EXEC once both flags are set, including when they set in the same cycle.
  - IDLE -> RD_EXEC on an AR handshake.
  - Write priority: when AWvalid and ARvalid are both high, ARready stays low, so the read waits.
  - RD_EXEC: one-cycle synchronous RAM read. Next cycle Rvalid=1 with Rdata/Rresp → RD_RESP.
  - RD_RESP: Rvalid, Rdata and Rresp are held stable until RReady=1 at a clock edge, then → IDLE with Rvalid=0.
  - WR_EXEC: applies the byte-masked write if in range, otherwise drops it. Clears both flags. Next cycle Bvalid=1 with Bresp → WR_RESP.
  - WR_RESP: Bvalid and Bresp held until Bready=1 at a clock edge, then → IDLE.
- Latency:
  - AR accept to Rvalid: 2 cycles (accept edge, RAM edge).
  - Second of AW/W accept to Bvalid: 2 cycles.
  - A back-to-back transaction can be accepted in the cycle after the response handshake.
- Outside IDLE: ARready, AWready and Wready are all 0.
- Out of range:
  - Read returns Rdata=ERR_DATA, Rresp=2'b10.
  - Write leaves RAM unchanged, Bresp=2'b10.
- Wstrb=4'b0000: no bytes change, Bresp=OKAY.
- Read after write to the same word in the next transaction returns the new data; there is no stale-read hazard.
- No combinational path from any input to any output except the IDLE ready terms, which depend on AWvalid.

Test Plan:
- Write 32'hCAFEBABE to 0x10 with Wstrb=4'hF, AW and W in the same cycle, Bready=1 → Bvalid 2 cycles later with Bresp=0. Then read 0x10 → Rdata=32'hCAFEBABE, Rresp=0, Rvalid 2 cycles after AR accept.
- Byte strobes: prefill 0x20 with 32'h11223344, write 32'hAABBCCDD with Wstrb=4'b0101 → a read returns 32'h11BB33DD.
- Split write: W at cycle 0, AW at cycle 3; AWready stays high, Wready drops after cycle 0 → exactly one RAM write, Bvalid 2 cycles after cycle 3.
- Backpressure and priority:
  - Hold RReady=0 for 5 cycles → Rvalid and Rdata stay constant and no new AR is accepted.
  - Assert ARvalid and AWvalid together → the write completes first, then the read is accepted.
- Out of range (MEM_WORDS=1024, BASE=0): read 0x1000 → Rdata=32'hDEAD_BEEF, Rresp=2'b10. Write 0x1000 → Bresp=2'b10 and word 0 is unchanged.
- Reset: assert rst after the AW handshake but before W → all valid/ready outputs are 0 next cycle, and the targeted word keeps its old value. Reset while Rvalid=1 → Rvalid=0 next cycle.
